// File: rtl/date_pkg.sv
// Shared constants and calendar helpers for the date counter.
// Optional macro GREGORIAN_LEAP_EN selects the full Gregorian leap rule;
// when it is undefined, every year divisible by 4 is a leap year.
package date_pkg;

  localparam int DAY_W = 5;
  localparam int MON_W = 4;

  localparam logic [MON_W-1:0] JAN = 4'd1;
  localparam logic [MON_W-1:0] FEB = 4'd2;
  localparam logic [MON_W-1:0] MAR = 4'd3;
  localparam logic [MON_W-1:0] APR = 4'd4;
  localparam logic [MON_W-1:0] MAY = 4'd5;
  localparam logic [MON_W-1:0] JUN = 4'd6;
  localparam logic [MON_W-1:0] JUL = 4'd7;
  localparam logic [MON_W-1:0] AUG = 4'd8;
  localparam logic [MON_W-1:0] SEP = 4'd9;
  localparam logic [MON_W-1:0] OCT = 4'd10;
  localparam logic [MON_W-1:0] NOV = 4'd11;
  localparam logic [MON_W-1:0] DEC = 4'd12;

  // Year is passed zero-extended to 32 bits so one function serves any YEAR_W.
  // Year 0 is divisible by 4, 100 and 400, so it is leap under both rules.
  function automatic logic is_leap(input logic [31:0] yr);
`ifdef GREGORIAN_LEAP_EN
    return (yr[1:0] == 2'b00) &&
           (((yr % 32'd100) != 32'd0) || ((yr % 32'd400) == 32'd0));
`else
    return (yr[1:0] == 2'b00);
`endif
  endfunction

  // Out-of-range month codes return 31; callers validate the month separately.
  function automatic logic [DAY_W-1:0] month_len(input logic [MON_W-1:0] mon,
                                                 input logic leap);
    logic [DAY_W-1:0] len;
    case (mon)
      APR, JUN, SEP, NOV: len = 5'd30;
      FEB:                len = leap ? 5'd29 : 5'd28;
      default:            len = 5'd31;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/month_len_calc.sv
// Combinational last-day-of-month lookup for a given month and year.
module month_len_calc
  import date_pkg::*;
#(
  parameter int YEAR_W = 12
) (
  input  logic [MON_W-1:0]  mon,
  input  logic [YEAR_W-1:0] year,
  output logic [DAY_W-1:0]  last
);

  // Leap status depends on the year supplied here, not on any stored date.
  assign last = month_len(mon, is_leap(32'(year)));

endmodule

// File: rtl/date_counter.sv
// Registered day/month/year calendar counter advanced by a daily tick.
// Supports validated loads and one-cycle rollover / load-error pulses.
// Optional macro GREGORIAN_LEAP_EN (see date_pkg) selects the leap rule.
module date_counter
  import date_pkg::*;
#(
  parameter int YEAR_W   = 12,
  parameter int RST_YEAR = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              load,
  input  logic [DAY_W-1:0]  ld_day,
  input  logic [MON_W-1:0]  ld_mon,
  input  logic [YEAR_W-1:0] ld_year,
  output logic [DAY_W-1:0]  day,
  output logic [MON_W-1:0]  mon,
  output logic [YEAR_W-1:0] year,
  output logic              eom,
  output logic              eoy,
  output logic              year_wrap,
  output logic              load_err
);

  localparam logic [YEAR_W-1:0] YEAR_MAX = '1;
  localparam logic [YEAR_W-1:0] RST_Y    = YEAR_W'(RST_YEAR);

  logic [DAY_W-1:0]  cur_last;
  logic [DAY_W-1:0]  ld_last;
  logic              ld_valid;

  logic [DAY_W-1:0]  day_n;
  logic [MON_W-1:0]  mon_n;
  logic [YEAR_W-1:0] year_n;
  logic              eom_n;
  logic              eoy_n;
  logic              wrap_n;
  logic              err_n;

  month_len_calc #(.YEAR_W(YEAR_W)) u_len_cur (
    .mon  (mon),
    .year (year),
    .last (cur_last)
  );

  month_len_calc #(.YEAR_W(YEAR_W)) u_len_ld (
    .mon  (ld_mon),
    .year (ld_year),
    .last (ld_last)
  );

  assign ld_valid = (ld_mon >= JAN) && (ld_mon <= DEC) &&
                    (ld_day != '0) && (ld_day <= ld_last);

  // Next date and pulses: load wins over tick, and a tick that coincides with
  // any load (accepted or rejected) is dropped.
  always_comb begin
    day_n  = day;
    mon_n  = mon;
    year_n = year;
    eom_n  = 1'b0;
    eoy_n  = 1'b0;
    wrap_n = 1'b0;
    err_n  = 1'b0;
    if (load) begin
      if (ld_valid) begin
        day_n  = ld_day;
        mon_n  = ld_mon;
        year_n = ld_year;
      end else begin
        err_n = 1'b1;
      end
    end else if (tick) begin
      if (day < cur_last) begin
        day_n = day + 5'd1;
      end else if (mon < DEC) begin
        day_n = 5'd1;
        mon_n = mon + 4'd1;
        eom_n = 1'b1;
      end else begin
        day_n  = 5'd1;
        mon_n  = JAN;
        year_n = year + YEAR_W'(1);
        eom_n  = 1'b1;
        eoy_n  = 1'b1;
        wrap_n = (year == YEAR_MAX);
      end
    end
  end

  // Date and pulse registers; pulses are rewritten every cycle so they last one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day       <= 5'd1;
      mon       <= JAN;
      year      <= RST_Y;
      eom       <= 1'b0;
      eoy       <= 1'b0;
      year_wrap <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      day       <= day_n;
      mon       <= mon_n;
      year      <= year_n;
      eom       <= eom_n;
      eoy       <= eoy_n;
      year_wrap <= wrap_n;
      load_err  <= err_n;
    end
  end

endmodule

// File: doc/date_counter.md
Name: date_counter

Overview:
- Registered calendar counter holding day, month and year.
- Advances one day per `tick` strobe, with correct month lengths and leap years.
- Successor to the combinational today-to-tomorrow logic; generalised with a parametrised year width, load port, rollover pulses and date validation.
- Sits below the RTC seconds/minutes chain; `tick` comes from the hours-rollover pulse.

Parameters:
- YEAR_W, 12, width of year register; year range 0 .. 2^YEAR_W-1.
- RST_YEAR, 2000, year value loaded on reset; must fit in YEAR_W.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  advance date by one day; one-cycle strobe, sampled on clk.
- load  input  1  load `ld_day`/`ld_mon`/`ld_year` this cycle.
- ld_day  input  5  day to load, 1..31.
- ld_mon  input  4  month to load, 1..12.
- ld_year  input  YEAR_W  year to load.
- day  output  5  current day of month, 1..31.
- mon  output  4  current month, 1..12.
- year  output  YEAR_W  current year.
- eom  output  1  one-cycle pulse: last tick crossed a month boundary.
- eoy  output  1  one-cycle pulse: last tick crossed a year boundary.
- year_wrap  output  1  one-cycle pulse: year wrapped from max to 0.
- load_err  output  1  one-cycle pulse: last load was rejected.

Behaviour:
- Reset (async assert, applied immediately):
  - day=1, mon=1, year=RST_YEAR.
  - eom=0, eoy=0, year_wrap=0, load_err=0.
  - A reset mid-operation discards any in-flight tick or load.
- Month length `last`:
  - 30 for months 4, 6, 9, 11.
  - Feb: 29 if leap, else 28.
  - All other months: 31.
- Leap rule (base): year divisible by 4; year 0 counts as leap.
- All updates happen on the rising clk edge. Pulses are registered in the same edge, so they are visible together with the new date and last exactly one cycle.
- Priority: `load` over `tick`. When both are high, the tick is dropped and no eom/eoy is produced.
- Tick step:
  - If day < last: day+1.
  - Else if mon < 12: day=1, mon+1, eom=1.
  - Else: day=1, mon=1, year+1, eom=1, eoy=1.
  - If year was 2^YEAR_W-1, year wraps to 0 and year_wrap=1 is asserted as well.
- Load validation:
  - Valid when ld_mon is in 1..12 and ld_day is in 1..last(ld_mon, ld_year).
  - Leap status is evaluated on `ld_year`, not the current year.
  - Valid: registers take the new values; all pulses are 0.
  - Invalid: date is unchanged and load_err=1 for one cycle.
- Latency: 1 cycle from tick/load to updated outputs. A tick on every cycle is legal; the counter advances every cycle.
- No state beyond the date and pulse registers. Outputs are never X after reset.

Optional Feature:
- Macro: GREGORIAN_LEAP_EN.
- Defined: full Gregorian rule. Leap if divisible by 4 and (not divisible by 100, or divisible by 400). Example: 2100 is not leap; 2000 is leap.
- Undefined: divisible-by-4 rule only. Example: 2100 is treated as leap.
- The macro affects both tick stepping and load validation.

Decomposition:
- Package `date_pkg`:
  - Month constants JAN..DEC (4-bit).
  - Constants DAY_W=5 and MON_W=4.
  - Function `is_leap(year)`, which carries the GREGORIAN_LEAP_EN conditional.
  - Function `month_len(mon, leap)` returning 5 bits.
- One combinational sub-module `month_len_calc`:
  - Inputs: mon, year. Output: last day.
  - Instantiated twice: once for the current date (tick path) and once for the load inputs (validation).
- Top level holds the registers, the priority mux and the pulse generation.

Test Plan:
- Reset while ticking -> outputs become 1/1/2000 immediately, all pulses 0. Release reset and tick -> 2/1/2000.
- Load 30/4/2023, then tick -> 1/5/2023 with eom=1, eoy=0. Next tick -> 2/5/2023 with eom=0.
- Load 28/2/2024, tick -> 29/2/2024; tick -> 1/3/2024, eom=1. Load 28/2/2023, tick -> 1/3/2023.
- Load 31/12/2023, tick -> 1/1/2024 with eom=1, eoy=1. Load 31/12/4095, tick -> 1/1/0 with year_wrap=1.
- Load 31/4/2023 -> load_err=1, date unchanged. Load 29/2/2023 -> load_err=1. Load 5/13/2023 -> load_err=1. Load and tick together with 10/6/2023 -> 10/6/2023, no eom.
- Load 28/2/2100, tick: with GREGORIAN_LEAP_EN -> 1/3/2100; without -> 29/2/2100. With the macro, load 29/2/2000 -> accepted.
